calc_result_display: RTL and testbench

Downstream display stage for `simple_calc`. It takes the calculator's 8-bit result and its carry/overflow flags and converts the result to decimal BCD with an iterative double-dabble FSM, or passes it through as hex. It then time-multiplexes four digits onto the board's active-low 7-segment display. The result appears as a decimal or hex number, and one digit shows the flag status.

---
 rtl/calc_result_display_if.sv | 21 ++
 rtl/calc_result_display.sv | 137 +++++++++++++
 tb/tb_calc_result_display.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/calc_result_display_if.sv
// Port bundle between simple_calc's result/flag outputs and the 7-segment display stage.
interface calc_result_display_if;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;
  logic       hex_mode;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;
  logic       busy;

  modport master (
    output result, carry_out, overflow, hex_mode,
    input  AN, SEG, DP, busy
  );

  modport slave (
    input  result, carry_out, overflow, hex_mode,
    output AN, SEG, DP, busy
  );
endinterface

// File: rtl/calc_result_display.sv
// Converts an 8-bit calculator result to decimal (double-dabble) or hex and
// scans four active-low 7-segment digits, with a flag digit on the left.
module calc_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input logic              clk,
  input logic              rst,
  calc_result_display_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_C     = 7'b1000110;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int n = 0; n < 3; n++) begin
      if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'h0: seg_code = 7'b1000000;
      4'h1: seg_code = 7'b1111001;
      4'h2: seg_code = 7'b0100100;
      4'h3: seg_code = 7'b0110000;
      4'h4: seg_code = 7'b0011001;
      4'h5: seg_code = 7'b0010010;
      4'h6: seg_code = 7'b0000010;
      4'h7: seg_code = 7'b1111000;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0010000;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b0000011;
      4'hC: seg_code = 7'b1000110;
      4'hD: seg_code = 7'b0100001;
      4'hE: seg_code = 7'b0000110;
      default: seg_code = 7'b0001110;
    endcase
  endfunction

  state_t            state;
  logic [10:0]       snap_in, snap_r, last_snap;
  logic              valid;
  logic [11:0]       bcd, bcd_adj;
  logic [7:0]        bin;
  logic [2:0]        bit_cnt;
  logic [3:0][6:0]   disp, disp_next;
  logic [CNT_W-1:0]  ref_cnt;
  logic [1:0]        idx;

  assign snap_in  = {bus.hex_mode, bus.overflow, bus.carry_out, bus.result};
  assign bcd_adj  = add3(bcd);
  assign bus.busy = (state != IDLE);
  assign bus.DP   = 1'b1;

  // Digit images built from the finished conversion; only loaded in COMMIT.
  always_comb begin
    disp_next = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
    if (snap_r[10]) begin
      disp_next[0] = seg_code(snap_r[3:0]);
      disp_next[1] = seg_code(snap_r[7:4]);
    end else begin
      disp_next[0] = seg_code(bcd[3:0]);
      if (bcd[11:4] != 8'd0) disp_next[1] = seg_code(bcd[7:4]);
      if (bcd[11:8] != 4'd0) disp_next[2] = seg_code(bcd[11:8]);
    end
    if (snap_r[9])      disp_next[3] = SEG_E;
    else if (snap_r[8]) disp_next[3] = SEG_C;
  end

  // Conversion stage: snapshot, 8 add-3/shift steps, commit to display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= 1'b0;
      snap_r    <= '0;
      last_snap <= '0;
      bcd       <= '0;
      bin       <= '0;
      bit_cnt   <= '0;
      disp      <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
    end else begin
      case (state)
        IDLE: begin
          if (!valid || snap_in != last_snap) begin
            snap_r  <= snap_in;
            bin     <= snap_in[7:0];
            bcd     <= '0;
            bit_cnt <= '0;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd     <= {bcd_adj[10:0], bin[7]};
          bin     <= {bin[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          disp      <= disp_next;
          last_snap <= snap_r;
          valid     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan stage: AN and SEG come from the same index on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= '0;
      bus.AN  <= 4'b1111;
      bus.SEG <= SEG_BLANK;
    end else begin
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      bus.AN  <= ~(4'b0001 << idx);
      bus.SEG <= disp[idx];
    end
  end

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display with a 4-cycle refresh period.
module tb_calc_result_display;
  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SE = 7'b0000110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  calc_result_display_if bus();

  calc_result_display #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [7:0] r, input logic c, input logic o, input logic h);
    bus.result    = r;
    bus.carry_out = c;
    bus.overflow  = o;
    bus.hex_mode  = h;
  endtask

  // Waits for a conversion to start and end; returns the busy length (0 on timeout).
  task automatic wait_conv(output int n);
    int k;
    n = 0;
    k = 0;
    while (bus.busy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    while (bus.busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (k >= 20) n = 0;
    repeat (2) @(negedge clk);
  endtask

  // Captures the segment pattern shown while digit i is lit (x on timeout).
  task automatic read_digit(input int i, output logic [6:0] s);
    logic [3:0] m;
    m = ~(4'b0001 << i);
    s = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.AN === m) begin s = bus.SEG; break; end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    logic [6:0] s;
    int nb, hi;
    set_in(8'h0E, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.AN !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", bus.AN); end
    total++; if (bus.SEG !== BLK) begin bad++; $display("FAIL reset_seg got=%b exp=%b", bus.SEG, BLK); end
    total++; if (bus.DP !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", bus.DP); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    nb = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) nb++;
      if (k % 4 == 0) begin
        exp_an = ~(4'b0001 << (k / 4));
        total++; if (bus.AN !== exp_an) begin bad++; $display("FAIL an_scan k=%0d got=%b exp=%b", k, bus.AN, exp_an); end
      end
    end
    total++; if (nb != 9) begin bad++; $display("FAIL reset_busy_len got=%0d exp=9", nb); end
    read_digit(0, s);
    total++; if (s !== S4) begin bad++; $display("FAIL r14_d0 got=%b exp=%b", s, S4); end
    read_digit(1, s);
    total++; if (s !== S1) begin bad++; $display("FAIL r14_d1 got=%b exp=%b", s, S1); end
    read_digit(2, s);
    total++; if (s !== BLK) begin bad++; $display("FAIL r14_d2 got=%b exp=%b", s, BLK); end
    read_digit(3, s);
    total++; if (s !== BLK) begin bad++; $display("FAIL r14_d3 got=%b exp=%b", s, BLK); end
    hi = 0;
    repeat (30) begin @(negedge clk); if (bus.busy !== 1'b0) hi++; end
    total++; if (hi != 0) begin bad++; $display("FAIL steady_idle busy_cycles=%0d exp=0", hi); end
  endtask

  task automatic test_max_value();
    logic [6:0] s;
    int n;
    set_in(8'hFF, 1'b0, 1'b0, 1'b0);
    wait_conv(n);
    total++; if (n != 9) begin bad++; $display("FAIL max_busy got=%0d exp=9", n); end
    read_digit(0, s);
    total++; if (s !== S5) begin bad++; $display("FAIL max_d0 got=%b exp=%b", s, S5); end
    read_digit(1, s);
    total++; if (s !== S5) begin bad++; $display("FAIL max_d1 got=%b exp=%b", s, S5); end
    read_digit(2, s);
    total++; if (s !== S2) begin bad++; $display("FAIL max_d2 got=%b exp=%b", s, S2); end
    read_digit(3, s);
    total++; if (s !== BLK) begin bad++; $display("FAIL max_d3 got=%b exp=%b", s, BLK); end
  endtask

  task automatic test_flags();
    logic [6:0] s;
    int n;
    set_in(8'h04, 1'b1, 1'b1, 1'b0);
    wait_conv(n);
    read_digit(3, s);
    total++; if (s !== SE) begin bad++; $display("FAIL flag_e got=%b exp=%b", s, SE); end
    read_digit(0, s);
    total++; if (s !== S4) begin bad++; $display("FAIL flag_d0 got=%b exp=%b", s, S4); end
    read_digit(1, s);
    total++; if (s !== BLK) begin bad++; $display("FAIL flag_d1 got=%b exp=%b", s, BLK); end
    read_digit(2, s);
    total++; if (s !== BLK) begin bad++; $display("FAIL flag_d2 got=%b exp=%b", s, BLK); end
    set_in(8'h04, 1'b1, 1'b0, 1'b0);
    wait_conv(n);
    total++; if (n != 9) begin bad++; $display("FAIL flag_reconv_busy got=%0d exp=9", n); end
    read_digit(3, s);
    total++; if (s !== SC) begin bad++; $display("FAIL flag_c got=%b exp=%b", s, SC); end
  endtask

  task automatic test_hex();
    logic [6:0] s;
    int n;
    set_in(8'hAB, 1'b0, 1'b0, 1'b1);
    wait_conv(n);
    total++; if (n != 9) begin bad++; $display("FAIL hex_busy got=%0d exp=9", n); end
    read_digit(0, s);
    total++; if (s !== SB) begin bad++; $display("FAIL hex_d0 got=%b exp=%b", s, SB); end
    read_digit(1, s);
    total++; if (s !== SA) begin bad++; $display("FAIL hex_d1 got=%b exp=%b", s, SA); end
    read_digit(2, s);
    total++; if (s !== BLK) begin bad++; $display("FAIL hex_d2 got=%b exp=%b", s, BLK); end
    read_digit(3, s);
    total++; if (s !== BLK) begin bad++; $display("FAIL hex_d3 got=%b exp=%b", s, BLK); end
  endtask

  task automatic test_mid_change();
    logic [3:0][6:0] exp14;
    logic [6:0] s, e;
    int k, n, di;
    exp14 = {BLK, BLK, S1, S4};
    set_in(8'h0E, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (bus.busy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_start busy=%b exp=1", bus.busy); end
    repeat (3) @(negedge clk);
    set_in(8'h64, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++; if (n != 6) begin bad++; $display("FAIL mid_first_rest got=%0d exp=6", n); end
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_second_busy j=%0d got=%b exp=1", j, bus.busy); end
      case (bus.AN)
        4'b1110: di = 0;
        4'b1101: di = 1;
        4'b1011: di = 2;
        4'b0111: di = 3;
        default: di = -1;
      endcase
      e = (di >= 0) ? exp14[di] : 7'bx;
      total++; if (di < 0 || bus.SEG !== e) begin bad++; $display("FAIL mid_shows14 j=%0d an=%b got=%b exp=%b", j, bus.AN, bus.SEG, e); end
    end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_second_end busy=%b exp=0", bus.busy); end
    repeat (2) @(negedge clk);
    read_digit(0, s);
    total++; if (s !== S0) begin bad++; $display("FAIL r100_d0 got=%b exp=%b", s, S0); end
    read_digit(1, s);
    total++; if (s !== S0) begin bad++; $display("FAIL r100_d1 got=%b exp=%b", s, S0); end
    read_digit(2, s);
    total++; if (s !== S1) begin bad++; $display("FAIL r100_d2 got=%b exp=%b", s, S1); end
  endtask

  task automatic test_reset_mid_conv();
    logic [6:0] s;
    int k, n;
    set_in(8'h2A, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (bus.busy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.AN !== 4'b1111) begin bad++; $display("FAIL rmid_an got=%b exp=1111", bus.AN); end
    total++; if (bus.SEG !== BLK) begin bad++; $display("FAIL rmid_seg got=%b exp=%b", bus.SEG, BLK); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    total++; if (bus.DP !== 1'b1) begin bad++; $display("FAIL rmid_dp got=%b exp=1", bus.DP); end
    @(negedge clk);
    rst = 1'b0;
    wait_conv(n);
    total++; if (n != 9) begin bad++; $display("FAIL rmid_busy_len got=%0d exp=9", n); end
    read_digit(0, s);
    total++; if (s !== S2) begin bad++; $display("FAIL r42_d0 got=%b exp=%b", s, S2); end
    read_digit(1, s);
    total++; if (s !== S4) begin bad++; $display("FAIL r42_d1 got=%b exp=%b", s, S4); end
    read_digit(2, s);
    total++; if (s !== BLK) begin bad++; $display("FAIL r42_d2 got=%b exp=%b", s, BLK); end
  endtask

  initial begin
    set_in(8'h00, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_max_value();
    test_flags();
    test_hex();
    test_mid_change();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
